// File: rtl/mmm_nlp_90b_ctrl.sv
// Montgomery modular-multiply sequencer around the 5-stage 90b NLP multiplier.
// Runs T=a*b, m=T*N' mod 2^IDW, P=m*N, then (T+P)>>IDW with a final conditional subtract.
module mmm_nlp_90b_ctrl #(
  parameter int IDW     = 90,
  parameter int ODW     = 181,
  parameter int MUL_LAT = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [IDW-1:0] i_a,
  input  logic [IDW-1:0] i_b,
  input  logic [IDW-1:0] i_n,
  input  logic [IDW-1:0] i_nprime,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [IDW-1:0] o_res,
  output logic           o_busy,
  output logic [IDW-1:0] o_mul_a,
  output logic [IDW-1:0] o_mul_b,
  output logic           o_mul_carry,
  input  logic [ODW-1:0] i_mul_res
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MUL_LAT);

  typedef enum logic [2:0] {
    IDLE, MUL_T, MUL_M, MUL_U, FINAL, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   n_q, n_d;
  logic [IDW-1:0]   np_q, np_d;
  logic [2*IDW-1:0] t_q, t_d;
  logic [ODW-1:0]   s_q, s_d;
  logic [IDW-1:0]   res_q, res_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   mul_a_q, mul_a_d;
  logic [IDW-1:0]   mul_b_q, mul_b_d;

  logic             phase_end;
  logic [IDW:0]     u;
  logic [IDW:0]     u_sub;
  logic             unused_bits;

  assign phase_end = (cnt_q == CNT_MAX);
  assign u         = s_q[ODW-1:IDW];
  assign u_sub     = u - {1'b0, n_q};

  // The multiplier operand registers double as storage for a, b and m.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    np_d    = np_q;
    t_d     = t_q;
    s_d     = s_q;
    res_d   = res_q;
    valid_d = valid_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          mul_a_d = i_a;
          mul_b_d = i_b;
          n_d     = i_n;
          np_d    = i_nprime;
          cnt_d   = '0;
          state_d = MUL_T;
        end
      end
      MUL_T, MUL_M, MUL_U: begin
        if (!phase_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (state_q == MUL_T) begin
            t_d     = i_mul_res[2*IDW-1:0];
            mul_a_d = i_mul_res[IDW-1:0];
            mul_b_d = np_q;
            state_d = MUL_M;
          end else if (state_q == MUL_M) begin
            mul_a_d = i_mul_res[IDW-1:0];
            mul_b_d = n_q;
            state_d = MUL_U;
          end else begin
            s_d     = {1'b0, t_q} + {1'b0, i_mul_res[2*IDW-1:0]};
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        res_d   = (u >= {1'b0, n_q}) ? u_sub[IDW-1:0] : u[IDW-1:0];
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      np_q    <= '0;
      t_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      np_q    <= np_d;
      t_q     <= t_d;
      s_q     <= s_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign unused_bits = ^{i_mul_res[ODW-1], s_q[IDW-1:0], u_sub[IDW]};

  assign o_ready     = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_valid     = valid_q;
  assign o_res       = res_q;
  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;
  assign o_mul_carry = 1'b0;

endmodule
